// File: rtl/face_detection_pkg.sv
// rtl/face_detection_pkg.sv - shared state encoding, command bits and register map
package face_detection_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FEED       = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_COLLECT    = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    localparam int CMD_START    = 0;
    localparam int CMD_ABORT    = 1;
    localparam int CMD_CLR_DONE = 2;
    localparam int CMD_IRQ_EN   = 3;

    localparam logic [2:0] ADDR_CMD    = 3'd0;
    localparam logic [2:0] ADDR_PIX    = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_RESULT = 3'd3;
    localparam logic [2:0] ADDR_CNT_LO = 3'd4;
    localparam logic [2:0] ADDR_CNT_HI = 3'd5;

endpackage

// File: rtl/face_detection_frame_sequencer_if.sv
// rtl/face_detection_frame_sequencer_if.sv - host register bus and core-side handshake bundle
interface face_detection_frame_sequencer_if #(
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] s_address;
    logic                  s_write;
    logic [7:0]            s_writedata;
    logic                  s_read;
    logic [7:0]            s_readdata;
    logic                  o_irq;
    logic                  o_core_reset;
    logic                  i_core_ready;
    logic                  o_core_pixel_valid;
    logic [7:0]            o_core_pixel;
    logic                  i_core_frame_end;
    logic                  o_core_result_req;
    logic                  i_core_result_valid;
    logic [7:0]            i_core_result_data;
    logic                  i_core_result_end;

    modport slave (
        input  s_address, s_write, s_writedata, s_read,
        output s_readdata, o_irq, o_core_reset,
        input  i_core_ready,
        output o_core_pixel_valid, o_core_pixel,
        input  i_core_frame_end,
        output o_core_result_req,
        input  i_core_result_valid, i_core_result_data, i_core_result_end
    );

    modport master (
        output s_address, s_write, s_writedata, s_read,
        input  s_readdata, o_irq, o_core_reset,
        output i_core_ready,
        input  o_core_pixel_valid, o_core_pixel,
        output i_core_frame_end,
        input  o_core_result_req,
        output i_core_result_valid, i_core_result_data, i_core_result_end
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - count-based synchronous FIFO with same-cycle push/pop and flush
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             s_clk,
    input  logic             s_reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot a push into a full FIFO needs
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge s_clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/face_detection_frame_sequencer.sv
// rtl/face_detection_frame_sequencer.sv - host register front end that feeds one frame to the core and collects results
module face_detection_frame_sequencer
    import face_detection_pkg::*;
#(
    parameter int ADDR_WIDTH   = 3,
    parameter int PIX_DEPTH    = 16,
    parameter int RES_DEPTH    = 16,
    parameter int FRAME_PIXELS = 19200,
    parameter int CNT_W        = 16
) (
    input  logic s_clk,
    input  logic s_reset,
    face_detection_frame_sequencer_if.slave bus
);
    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   pix_count;
    logic [15:0]        cnt_ext;
    logic               overflow;
    logic               irq_en;
    logic               core_reset;
    logic               pixel_valid;
    logic [7:0]         pixel;
    logic [7:0]         readdata;

    logic               cmd_wr, start, abort, clr_done;
    logic               pix_wr, res_rd;
    logic               pix_push, pix_pop, pix_drop, pix_full, pix_empty;
    logic               res_push, res_pop, res_drop, res_full, res_empty;
    logic [7:0]         pix_dout, res_dout;
    logic               frame_last, short_frame, start_ok, done;

    assign cmd_wr   = bus.s_write && (bus.s_address == ADDR_WIDTH'(ADDR_CMD));
    assign start    = cmd_wr && bus.s_writedata[CMD_START];
    assign abort    = cmd_wr && bus.s_writedata[CMD_ABORT];
    assign clr_done = cmd_wr && bus.s_writedata[CMD_CLR_DONE];
    assign pix_wr   = bus.s_write && (bus.s_address == ADDR_WIDTH'(ADDR_PIX));
    assign res_rd   = bus.s_read && (bus.s_address == ADDR_WIDTH'(ADDR_RESULT));

    assign done     = (state == ST_DONE);
    assign start_ok = start && !abort && (state == ST_IDLE || state == ST_DONE);

    assign pix_pop    = (state == ST_FEED) && !pix_empty && bus.i_core_ready;
    assign frame_last = pix_pop && (pix_count == CNT_W'(FRAME_PIXELS - 1));
    assign pix_push   = pix_wr && (state == ST_IDLE || state == ST_FEED) && (!pix_full || pix_pop);
    assign pix_drop   = pix_wr && !pix_push;

    assign res_pop  = res_rd && !res_empty;
    assign res_push = (state == ST_COLLECT) && bus.i_core_result_valid && (!res_full || res_pop);
    assign res_drop = (state == ST_COLLECT) && bus.i_core_result_valid && !res_push;

    // a frame_end before the last pixel went out marks a short frame
    assign short_frame = (state == ST_FEED) && bus.i_core_frame_end && !frame_last;

    sync_fifo #(.WIDTH(8), .DEPTH(PIX_DEPTH)) u_pix_fifo (
        .s_clk(s_clk), .s_reset(s_reset), .flush(abort),
        .push(pix_push), .din(bus.s_writedata),
        .pop(pix_pop), .dout(pix_dout), .full(pix_full), .empty(pix_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RES_DEPTH)) u_res_fifo (
        .s_clk(s_clk), .s_reset(s_reset), .flush(abort),
        .push(res_push), .din(bus.i_core_result_data),
        .pop(res_pop), .dout(res_dout), .full(res_full), .empty(res_empty)
    );

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:       if (start) state_next = ST_FEED;
                ST_FEED:       if (frame_last) state_next = ST_WAIT_FRAME;
                               else if (bus.i_core_frame_end) state_next = ST_COLLECT;
                ST_WAIT_FRAME: if (bus.i_core_frame_end) state_next = ST_COLLECT;
                ST_COLLECT:    if (bus.i_core_result_end) state_next = ST_DONE;
                ST_DONE:       if (start) state_next = ST_FEED;
                               else if (clr_done) state_next = ST_IDLE;
                default:       state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            state       <= ST_IDLE;
            pix_count   <= '0;
            overflow    <= 1'b0;
            irq_en      <= 1'b0;
            core_reset  <= 1'b0;
            pixel_valid <= 1'b0;
            pixel       <= '0;
        end else begin
            state       <= state_next;
            core_reset  <= abort;
            pixel_valid <= pix_pop && !abort;
            if (pix_pop) pixel <= pix_dout;
            if (cmd_wr) irq_en <= bus.s_writedata[CMD_IRQ_EN];

            if (abort || start_ok)  pix_count <= '0;
            else if (pix_pop)       pix_count <= pix_count + CNT_W'(1);

            if (abort || start_ok)  overflow <= 1'b0;
            else if (pix_drop || res_drop || short_frame) overflow <= 1'b1;
        end
    end

    assign cnt_ext = 16'(pix_count);

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            readdata <= '0;
        end else if (bus.s_read) begin
            case (bus.s_address)
                ADDR_WIDTH'(ADDR_STATUS): readdata <= {3'(state), irq_en, res_empty, pix_full, overflow, done};
                ADDR_WIDTH'(ADDR_RESULT): readdata <= res_pop ? res_dout : 8'h00;
                ADDR_WIDTH'(ADDR_CNT_LO): readdata <= cnt_ext[7:0];
                ADDR_WIDTH'(ADDR_CNT_HI): readdata <= cnt_ext[15:8];
                default:                  readdata <= 8'h00;
            endcase
        end
    end

    assign bus.s_readdata         = readdata;
    assign bus.o_irq              = done && irq_en;
    assign bus.o_core_reset       = core_reset;
    assign bus.o_core_pixel_valid = pixel_valid;
    assign bus.o_core_pixel       = pixel;
    assign bus.o_core_result_req  = (state == ST_COLLECT) && !res_full;
endmodule

// File: tb/tb_face_detection_frame_sequencer.sv
// tb/tb_face_detection_frame_sequencer.sv - directed self-checking bench for the frame sequencer
module tb_face_detection_frame_sequencer;
    logic s_clk = 1'b0;
    logic s_reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc_no = 0;
    int   rst_hi = 0;
    logic [7:0] pix_q[$];
    int         pix_cyc_q[$];
    logic [7:0] d;
    int         n0, n1;

    always #5 s_clk = ~s_clk;

    face_detection_frame_sequencer_if #(.ADDR_WIDTH(3)) bus ();

    face_detection_frame_sequencer #(
        .ADDR_WIDTH(3), .PIX_DEPTH(16), .RES_DEPTH(2), .FRAME_PIXELS(4), .CNT_W(16)
    ) dut (
        .s_clk(s_clk),
        .s_reset(s_reset),
        .bus(bus)
    );

    always @(posedge s_clk) cyc_no++;

    always @(negedge s_clk) begin
        if (bus.o_core_pixel_valid) begin
            pix_q.push_back(bus.o_core_pixel);
            pix_cyc_q.push_back(cyc_no);
        end
        if (bus.o_core_reset) rst_hi++;
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge s_clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] v);
        bus.s_address = a;
        bus.s_writedata = v;
        bus.s_write = 1'b1;
        cyc();
        bus.s_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        bus.s_address = a;
        bus.s_read = 1'b1;
        cyc();
        bus.s_read = 1'b0;
        v = bus.s_readdata;
    endtask

    task automatic frame_end_pulse();
        bus.i_core_frame_end = 1'b1;
        cyc();
        bus.i_core_frame_end = 1'b0;
    endtask

    task automatic core_result(input logic [7:0] v, input logic last);
        bus.i_core_result_valid = 1'b1;
        bus.i_core_result_data = v;
        bus.i_core_result_end = last;
        cyc();
        bus.i_core_result_valid = 1'b0;
        bus.i_core_result_end = 1'b0;
    endtask

    initial begin
        bus.s_address = '0;
        bus.s_write = 1'b0;
        bus.s_writedata = '0;
        bus.s_read = 1'b0;
        bus.i_core_ready = 1'b1;
        bus.i_core_frame_end = 1'b0;
        bus.i_core_result_valid = 1'b0;
        bus.i_core_result_data = '0;
        bus.i_core_result_end = 1'b0;
        repeat (2) cyc();
        check("rst_valid", 16'(bus.o_core_pixel_valid), 16'h0);
        check("rst_core_reset", 16'(bus.o_core_reset), 16'h0);
        check("rst_irq", 16'(bus.o_irq), 16'h0);
        check("rst_req", 16'(bus.o_core_result_req), 16'h0);
        check("rst_readdata", 16'(bus.s_readdata), 16'h0);
        s_reset = 1'b0;
        cyc();
        rd(3'd2, d); check("rst_status", 16'(d), 16'h08);
        rd(3'd7, d); check("unmapped", 16'(d), 16'h00);

        // frame 1: ready held high, 4 strobes back to back
        for (int i = 0; i < 4; i++) wr(3'd1, 8'h11 + 8'(i));
        wr(3'd0, 8'h01);
        repeat (6) cyc();
        check("f1_strobes", 16'(pix_q.size()), 16'd4);
        for (int i = 0; i < 4 && i < pix_q.size(); i++) begin
            check("f1_byte", 16'(pix_q[i]), 16'(8'h11 + 8'(i)));
            check("f1_consec", 16'(pix_cyc_q[i] - pix_cyc_q[0]), 16'(i));
        end
        rd(3'd2, d); check("f1_status", 16'(d), 16'h48);
        rd(3'd4, d); check("f1_cnt_lo", 16'(d), 16'h04);
        rd(3'd5, d); check("f1_cnt_hi", 16'(d), 16'h00);

        // results 0xA5, 0x5A
        frame_end_pulse();
        check("c1_req", 16'(bus.o_core_result_req), 16'h1);
        core_result(8'hA5, 1'b0);
        core_result(8'h5A, 1'b1);
        rd(3'd2, d); check("c1_status_done", 16'(d), 16'h81);
        check("c1_irq_off", 16'(bus.o_irq), 16'h0);
        wr(3'd0, 8'h08);
        check("c1_irq_on", 16'(bus.o_irq), 16'h1);
        rd(3'd3, d); check("c1_pop0", 16'(d), 16'hA5);
        rd(3'd3, d); check("c1_pop1", 16'(d), 16'h5A);
        rd(3'd3, d); check("c1_pop_empty", 16'(d), 16'h00);

        // frame 2 with a 3-cycle ready stall
        wr(3'd0, 8'h0C);
        check("f2_irq_clr", 16'(bus.o_irq), 16'h0);
        for (int i = 0; i < 4; i++) wr(3'd1, 8'h21 + 8'(i));
        pix_q.delete();
        pix_cyc_q.delete();
        wr(3'd0, 8'h09);
        cyc(); cyc();
        bus.i_core_ready = 1'b0;
        cyc();
        n0 = pix_q.size();
        cyc(); cyc();
        n1 = pix_q.size();
        bus.i_core_ready = 1'b1;
        check("f2_before_stall", 16'(n0), 16'd2);
        check("f2_no_strobe_low", 16'(n1), 16'd2);
        repeat (6) cyc();
        check("f2_strobes", 16'(pix_q.size()), 16'd4);
        for (int i = 0; i < 4 && i < pix_q.size(); i++)
            check("f2_byte", 16'(pix_q[i]), 16'(8'h21 + 8'(i)));
        rd(3'd2, d); check("f2_status", 16'(d), 16'h58);

        // result FIFO depth 2: req drops when full, returns after a pop
        frame_end_pulse();
        check("r_req0", 16'(bus.o_core_result_req), 16'h1);
        core_result(8'hB1, 1'b0);
        core_result(8'hB2, 1'b0);
        check("r_req_full", 16'(bus.o_core_result_req), 16'h0);
        rd(3'd3, d); check("r_pop_b1", 16'(d), 16'hB1);
        check("r_req_back", 16'(bus.o_core_result_req), 16'h1);
        core_result(8'hB3, 1'b1);
        rd(3'd3, d); check("r_pop_b2", 16'(d), 16'hB2);
        rd(3'd3, d); check("r_pop_b3", 16'(d), 16'hB3);
        rd(3'd3, d); check("r_pop_empty", 16'(d), 16'h00);
        rd(3'd2, d); check("r_status", 16'(d), 16'h99);
        check("r_irq", 16'(bus.o_irq), 16'h1);

        // short frame into COLLECT, then ABORT
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h31);
        cyc();
        frame_end_pulse();
        rd(3'd2, d); check("a_status_short", 16'(d), 16'h6A);
        rd(3'd4, d); check("a_cnt_pre", 16'(d), 16'h01);
        core_result(8'hC1, 1'b0);
        rst_hi = 0;
        wr(3'd0, 8'h02);
        check("a_core_reset_hi", 16'(bus.o_core_reset), 16'h1);
        cyc();
        check("a_core_reset_lo", 16'(bus.o_core_reset), 16'h0);
        check("a_reset_cycles", 16'(rst_hi), 16'd1);
        rd(3'd2, d); check("a_status", 16'(d), 16'h08);
        rd(3'd4, d); check("a_cnt_lo", 16'(d), 16'h00);
        rd(3'd5, d); check("a_cnt_hi", 16'(d), 16'h00);

        // pixel FIFO overflow in IDLE
        bus.i_core_ready = 1'b0;
        for (int i = 0; i < 17; i++) wr(3'd1, 8'h40 + 8'(i));
        rd(3'd2, d); check("o_status", 16'(d), 16'h0E);
        wr(3'd0, 8'h01);
        rd(3'd2, d); check("o_start_clears", 16'(d), 16'h2C);
        pix_q.delete();
        bus.i_core_ready = 1'b1;
        repeat (6) cyc();
        check("o_strobes", 16'(pix_q.size()), 16'd4);
        if (pix_q.size() == 4) begin
            check("o_first", 16'(pix_q[0]), 16'h40);
            check("o_last", 16'(pix_q[3]), 16'h43);
        end
        rd(3'd2, d); check("o_status_wait", 16'(d), 16'h48);

        // asynchronous reset mid-cycle
        #3 s_reset = 1'b1;
        #1;
        check("ar_readdata", 16'(bus.s_readdata), 16'h00);
        check("ar_core_reset", 16'(bus.o_core_reset), 16'h0);
        check("ar_valid", 16'(bus.o_core_pixel_valid), 16'h0);
        cyc();
        s_reset = 1'b0;
        cyc();
        rd(3'd2, d); check("ar_status", 16'(d), 16'h08);
        rd(3'd4, d); check("ar_cnt", 16'(d), 16'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
